cam_burst_writer: RTL

Packs the camera byte stream into 16-bit words, buffers them in a small FIFO and drains them to the PSRAM dual-port front-end as fixed-length burst writes on the application-3 port. It sits between the camera capture logic, whose pixel bytes are already synchronised to `clk`, and `dualport_frontend`. It generates frame-buffer addresses, so the video pipeline reads a stable frame layout starting at `BASE_ADDR`.

---
 rtl/cam_wr_pkg.sv | 14 +
 rtl/cam_wr_fifo.sv | 59 +++++
 rtl/cam_burst_writer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cam_wr_pkg.sv
// rtl/cam_wr_pkg.sv - shared FSM state type and frame/burst constants for the camera burst writer
package cam_wr_pkg;

    localparam int ADDR_W          = 23;
    localparam int FRAME_WORDS_DEF = 153600;
    localparam int BURST_LEN_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BURST
    } state_t;

endpackage

// File: rtl/cam_wr_fifo.sv
// rtl/cam_wr_fifo.sv - synchronous show-ahead word FIFO with full/empty flags and level
module cam_wr_fifo #(
    parameter int AW = 6,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == DEPTH);
    assign empty   = (level == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; the head is only meaningful while not empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_burst_writer.sv
// rtl/cam_burst_writer.sv - camera byte packer and PSRAM burst writer; CAM_WR_TESTPAT_EN replaces bytes with a counter
import cam_wr_pkg::*;

module cam_burst_writer #(
    parameter int                BURST_LEN   = BURST_LEN_DEF,
    parameter int                FIFO_AW     = 6,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                FRAME_WORDS = FRAME_WORDS_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [7:0]        pix_data,
    input  logic              op_begun,
    input  logic              data_ok,
    output logic              mem_wr,
    output logic              mem_burst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              overflow,
    output logic [FIFO_AW:0]  fifo_level
);

    localparam logic [FIFO_AW:0] BL       = (FIFO_AW+1)'(BURST_LEN);
    localparam logic [FIFO_AW:0] BL_LAST  = (FIFO_AW+1)'(BURST_LEN - 1);
    localparam logic [ADDR_W:0]  END_ADDR = {1'b0, BASE_ADDR} + (ADDR_W+1)'(FRAME_WORDS);

    state_t           state;
    logic             pending;
    logic             phase;
    logic [7:0]       hi_byte;
    logic [7:0]       byte_in;
    logic [FIFO_AW:0] beat_cnt;
    logic             accept;
    logic             push;
    logic             pop;
    logic             fifo_clear;
    logic             fifo_full;
    logic             fifo_empty;
    logic [15:0]      fifo_head;
    logic [ADDR_W:0]  next_addr;

    // The frame_start cycle itself already counts as pending.
    assign accept     = pix_valid && !pending && !frame_start;
    assign push       = accept && phase && !fifo_full;
    assign pop        = (state == BURST) && data_ok;
    assign fifo_clear = (state == IDLE) && pending;
    assign next_addr  = {1'b0, mem_addr} + (ADDR_W+1)'(BURST_LEN);
    assign mem_data   = fifo_empty ? '0 : fifo_head;

`ifdef CAM_WR_TESTPAT_EN
    logic [7:0] pat_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_cnt <= '0;
        end else if (frame_start) begin
            pat_cnt <= '0;
        end else if (accept) begin
            pat_cnt <= pat_cnt + 1'b1;
        end
    end

    assign byte_in = pat_cnt;
`else
    assign byte_in = pix_data;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= 1'b0;
            phase    <= 1'b0;
            hi_byte  <= '0;
            overflow <= 1'b0;
        end else begin
            if (frame_start) begin
                pending <= 1'b1;
            end else if (fifo_clear) begin
                pending <= 1'b0;
            end
            if (frame_start || pending) begin
                phase <= 1'b0;
            end else if (accept) begin
                phase <= ~phase;
                if (!phase) begin
                    hi_byte <= byte_in;
                end else if (fifo_full) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mem_wr    <= 1'b0;
            mem_burst <= 1'b0;
            mem_addr  <= BASE_ADDR;
            beat_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        mem_addr <= BASE_ADDR;
                    end else if (fifo_level >= BL) begin
                        state     <= REQ;
                        mem_wr    <= 1'b1;
                        mem_burst <= 1'b1;
                    end
                end
                REQ: begin
                    if (op_begun) begin
                        state     <= BURST;
                        mem_wr    <= 1'b0;
                        mem_burst <= 1'b0;
                        beat_cnt  <= '0;
                    end
                end
                BURST: begin
                    if (data_ok) begin
                        if (beat_cnt == BL_LAST) begin
                            state    <= IDLE;
                            mem_addr <= (next_addr >= END_ADDR) ? BASE_ADDR : next_addr[ADDR_W-1:0];
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    cam_wr_fifo #(
        .AW (FIFO_AW),
        .DW (16)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (fifo_clear),
        .push      (push),
        .push_data ({hi_byte, byte_in}),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

endmodule
